// File: rtl/sprite_animator.sv
// Sprite renderer: 3-stage pixel pipeline into a 1-cycle ROM,
// plus a frame sequencer stepping on vsync ticks.
module sprite_animator #(
  parameter int          WIDTH  = 34,
  parameter int          HEIGHT = 36,
  parameter int          FRAMES = 14,
  parameter int          FW     = 4,
  parameter int          ADDR_W = 16,
  parameter int          HOLD   = 8,
  parameter logic [15:0] KEY    = 16'hffff
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        col,
  input  logic [8:0]        row,
  input  logic [9:0]        posx,
  input  logic [8:0]        posy,
  input  logic              flip_h,
  input  logic              anim_load,
  input  logic [FW-1:0]     anim_base,
  input  logic [FW-1:0]     anim_len,
  input  logic              anim_loop,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       color,
  output logic              opaque,
  output logic [FW-1:0]     cur_frame,
  output logic              done
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int FB = FW + 1;

  typedef enum logic [1:0] {
    STATIC,
    PLAY,
    HOLDLAST
  } state_e;

  state_e        state_q, state_d;
  logic [FB-1:0] frame_q, frame_d;
  logic [FB-1:0] base_q, base_d;
  logic [FB-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          loop_q, loop_d;
  logic          done_q, done_d;
  logic [FW-1:0] len_eff;
  logic [FB-1:0] frame_cl;

  // One extra bit keeps base+len-1 from wrapping past 2^FW.
  assign len_eff  = (anim_len == '0) ? FW'(1) : anim_len;
  assign frame_cl = (frame_q >= FB'(FRAMES)) ?
                    FB'(FRAMES - 1) : frame_q;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    base_d  = base_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    if (anim_load) begin
      frame_d = {1'b0, anim_base};
      base_d  = {1'b0, anim_base};
      last_d  = {1'b0, anim_base} + {1'b0, len_eff} - FB'(1);
      cnt_d   = '0;
      loop_d  = anim_loop;
      state_d = (len_eff > FW'(1)) ? PLAY : STATIC;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (frame_tick) begin
            if (cnt_q == CW'(HOLD - 1)) begin
              cnt_d = '0;
              if (frame_q >= last_q) begin
                if (loop_q) begin
                  frame_d = base_q;
                end else begin
                  done_d  = 1'b1;
                  state_d = HOLDLAST;
                end
              end else begin
                frame_d = frame_q + FB'(1);
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STATIC;
      frame_q <= '0;
      base_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      base_q  <= base_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

  logic [10:0]       xend;
  logic [9:0]        yend;
  logic              hit;
  logic [9:0]        dx, x;
  logic [8:0]        dy;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit1_q, hit2_q;
  logic [15:0]       color_q, color_d;
  logic              opaque_q, opaque_d;

  // Wide sums so a sprite hanging off the right/bottom edge never wraps.
  assign xend = {1'b0, posx} + 11'(WIDTH);
  assign yend = {1'b0, posy} + 10'(HEIGHT);
  assign hit  = (col >= posx) && ({1'b0, col} < xend) &&
                (row >= posy) && ({1'b0, row} < yend);
  assign dx   = col - posx;
  assign dy   = row - posy;
  assign x    = flip_h ? (10'(WIDTH - 1) - dx) : dx;

  assign addr_d = ADDR_W'(frame_cl) * ADDR_W'(WIDTH * HEIGHT) +
                  ADDR_W'(dy) * ADDR_W'(WIDTH) + ADDR_W'(x);
  assign rom_addr_d = hit ? addr_d : rom_addr_q;

  always_comb begin
    color_d  = KEY;
    opaque_d = 1'b0;
    if (hit2_q && (rom_data != KEY)) begin
      color_d  = rom_data;
      opaque_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      color_q    <= KEY;
      opaque_q   <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      hit1_q     <= hit;
      hit2_q     <= hit1_q;
      color_q    <= color_d;
      opaque_q   <= opaque_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign color     = color_q;
  assign opaque    = opaque_q;
  assign cur_frame = frame_cl[FW-1:0];
  assign done      = done_q;

endmodule

// File: doc/sprite_animator.md
SPRITE_ANIMATOR -- requirements
Module: sprite_animator

Interface
REQ-001 Parameter WIDTH, default 34, sprite width in pixels.
REQ-002 Parameter HEIGHT, default 36, sprite height in pixels.
REQ-003 Parameter FRAMES, default 14, number of frames stored back-to-back in the external ROM.
REQ-004 Parameter FW, default 4, frame-index width; SHALL satisfy 2^FW >= FRAMES.
REQ-005 Parameter ADDR_W, default 16, ROM address width; SHALL satisfy 2^ADDR_W >= FRAMES*WIDTH*HEIGHT.
REQ-006 Parameter HOLD, default 8, frame_tick pulses per animation step (>=1).
REQ-007 Parameter KEY, default 16'hffff, transparent colour value.
REQ-008 clk  in  1  system clock; all logic on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 col  in  10  VGA scan column.
REQ-011 row  in  9  VGA scan row.
REQ-012 posx  in  10  sprite top-left column.
REQ-013 posy  in  9  sprite top-left row.
REQ-014 flip_h  in  1  1 = mirror sprite horizontally.
REQ-015 anim_load  in  1  one-cycle pulse: start sequence from anim_base.
REQ-016 anim_base  in  FW  first frame of sequence.
REQ-017 anim_len  in  FW  frame count of sequence (0 treated as 1).
REQ-018 anim_loop  in  1  1 = loop, 0 = one-shot; sampled on anim_load.
REQ-019 frame_tick  in  1  one-cycle pulse per video frame (vsync).
REQ-020 rom_addr  out  ADDR_W  registered address to external 1-cycle-latency synchronous ROM.
REQ-021 rom_data  in  16  ROM data, valid one cycle after rom_addr.
REQ-022 color  out  16  registered pixel colour.
REQ-023 opaque  out  1  registered; 1 = color is a visible sprite pixel.
REQ-024 cur_frame  out  FW  frame currently being rendered.
REQ-025 done  out  1  one-cycle pulse when a one-shot sequence ends.

Function
REQ-026 hit SHALL be col>=posx & col<posx+WIDTH & row>=posy & row<posy+HEIGHT, sums computed at 11/10 bits so no wrap at screen edge.
REQ-027 x SHALL be (col-posx) when flip_h=0, else WIDTH-1-(col-posx); y = row-posy.
REQ-028 rom_addr SHALL register cur_frame*WIDTH*HEIGHT + y*WIDTH + x when hit, else hold previous value; hit and flip-free state pipelined alongside.
REQ-029 Pipeline: col/row at cycle N -> rom_addr at N+1 -> rom_data at N+2 -> color/opaque valid at N+3; latency fixed at 3, throughput one pixel per cycle.
REQ-030 At N+3: delayed hit=0 -> color=KEY, opaque=0; hit=1 and rom_data==KEY -> color=KEY, opaque=0; else color=rom_data, opaque=1.
REQ-031 FSM states STATIC, PLAY, HOLDLAST; reset state STATIC.
REQ-032 anim_load: cur_frame<=anim_base, tick counter<=0, loop flag<=anim_loop; next state PLAY if effective length>1, else STATIC.
REQ-033 PLAY, frame_tick: counter increments; at counter==HOLD-1 counter<=0 and frame advances.
REQ-034 Advance at last frame (anim_base+len-1, computed FW+1 bits): loop=1 -> cur_frame<=anim_base; loop=0 -> stay, done=1 for one cycle, state HOLDLAST.
REQ-035 STATIC/HOLDLAST: frame_tick ignored; cur_frame held until next anim_load.
REQ-036 anim_load and frame_tick same cycle: load wins, tick discarded.
REQ-037 Any frame index >= FRAMES SHALL be clamped to FRAMES-1 for addressing and cur_frame.
REQ-038 cur_frame changes only on frame_tick or anim_load edges; no other output depends on anim_base/anim_len between loads (values latched on load).

Reset
REQ-039 rst=1 at a clock edge: rom_addr=0, color=KEY, opaque=0, cur_frame=0, counter=0, done=0, state STATIC, loop flag 0, pipeline hit flags 0.
REQ-040 rst mid-sequence or mid-line SHALL abort immediately; first valid color follows 3 cycles after rst deasserts.

Verification
REQ-041 posx=100,posy=50, frame 0, col=100,row=50 -> rom_addr=0 at N+1; rom_data=16'h1234 -> color=1234, opaque=1 at N+3.
REQ-042 Same, flip_h=1, col=100,row=51 -> rom_addr=34+33=67; col=134 -> opaque=0, color=FFFF.
REQ-043 anim_load base=3,len=2,loop=1, HOLD=8, 24 frame_ticks -> cur_frame 3->4 after tick 8, ->3 after 16, ->4 after 24; rom_addr base 3*1224=3672.
REQ-044 anim_load base=10,len=4,loop=0, 32 ticks -> frames 10..13, done pulses once at tick 32... (after 4th advance attempt), cur_frame stays 13.
REQ-045 anim_load base=13,len=3 -> clamp: cur_frame never exceeds 13; posx=1020 -> hit math no wrap, col=2 gives opaque=0.
REQ-046 anim_load coincident with frame_tick, then rst mid-PLAY -> load wins; after rst all outputs at REQ-039 values.
